// File: rtl/glyph_overlay_ctrl.sv
// glyph_overlay_ctrl: arms glyph requests per frame, maps pixels to ROM rows.
// Optional blinking is enabled with `define GLYPH_BLINK_EN.
module glyph_overlay_ctrl #(
  parameter int CW           = 10,
  parameter int X0           = 304,
  parameter int Y0           = 232,
  parameter int DISP_FRAMES  = 120,
  parameter int BLINK_FRAMES = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          pix_valid,
  input  logic [CW-1:0] pix_x,
  input  logic [CW-1:0] pix_y,
  input  logic          req_valid,
  input  logic [2:0]    req_code,
  output logic          req_ready,
  output logic          req_err,
  output logic          busy,
  output logic          rom_en,
  output logic [6:0]    rom_addr,
  input  logic [7:0]    rom_data,
  output logic          overlay_px,
  output logic          overlay_valid
);

  localparam int FW = $clog2(DISP_FRAMES + 1);

  localparam logic [CW:0]   XL  = (CW+1)'(X0);
  localparam logic [CW:0]   XH  = (CW+1)'(X0 + 8);
  localparam logic [CW:0]   YL  = (CW+1)'(Y0);
  localparam logic [CW:0]   YH  = (CW+1)'(Y0 + 16);
  localparam logic [CW-1:0] X0C = CW'(X0);
  localparam logic [CW-1:0] Y0C = CW'(Y0);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHOW
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] col;
    logic [6:0] addr;
  } s1_t;

  state_t        state_q, state_d;
  logic [2:0]    code_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          accept, good, last_frame;
  logic          show_vis;
  logic          in_x, in_y, hit;
  logic [CW:0]   xw, yw;
  logic [3:0]    row;
  logic [2:0]    col;
  s1_t           s1_d, s1_q;
  logic          err_q;

  assign req_ready  = (state_q != ARMED);
  assign busy       = (state_q != IDLE);
  assign req_err    = err_q;
  assign accept     = req_valid & req_ready;
  assign good       = accept & (req_code != 3'd7);
  assign last_frame = (fcnt_q == FW'(DISP_FRAMES - 1));

  // Next state and frame counter; a fresh accept beats the final frame.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (good) state_d = ARMED;
      end
      ARMED: begin
        if (frame_start) begin
          state_d = SHOW;
          fcnt_d  = '0;
        end
      end
      SHOW: begin
        if (good) begin
          state_d = ARMED;
        end else if (frame_start) begin
          if (last_frame) state_d = IDLE;
          else            fcnt_d  = fcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, frame counter, latched code and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      err_q   <= accept & (req_code == 3'd7);
      if (good) code_q <= req_code;
    end
  end

`ifdef GLYPH_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          vis_q, vis_d;

  // Blink phase: visible on SHOW entry, toggles every BLINK_FRAMES frames.
  always_comb begin
    bcnt_d = bcnt_q;
    vis_d  = vis_q;
    if (state_q == ARMED && frame_start) begin
      bcnt_d = '0;
      vis_d  = 1'b1;
    end else if (state_q == SHOW && frame_start) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d = '0;
        vis_d  = ~vis_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Blink phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      vis_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      vis_q  <= vis_d;
    end
  end

  assign show_vis = vis_d;
`else
  assign show_vis = 1'b1;
`endif

  assign xw   = {1'b0, pix_x};
  assign yw   = {1'b0, pix_y};
  assign in_x = (xw >= XL) && (xw < XH);
  assign in_y = (yw >= YL) && (yw < YH);
  assign row  = pix_y[3:0] - Y0C[3:0];
  assign col  = pix_x[2:0] - X0C[2:0];

  // Stage 1 hit uses the next state so leaving SHOW blanks at once.
  always_comb begin
    hit       = (state_d == SHOW) & show_vis & pix_valid & in_x & in_y;
    s1_d      = '0;
    s1_d.hit  = hit;
    if (hit) begin
      s1_d.col  = col;
      s1_d.addr = {code_q, row};
    end
  end

  // Stage 1 register drives the ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else        s1_q <= s1_d;
  end

  assign rom_en   = s1_q.hit;
  assign rom_addr = s1_q.addr;

  // Stage 2: pick the column bit, MSB is the leftmost pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overlay_valid <= 1'b0;
      overlay_px    <= 1'b0;
    end else begin
      overlay_valid <= s1_q.hit;
      overlay_px    <= s1_q.hit & rom_data[~s1_q.col];
    end
  end

endmodule

// File: tb/tb_glyph_overlay_ctrl.sv
// tb_glyph_overlay_ctrl: directed checks of glyph_overlay_ctrl.
// Uses DISP_FRAMES=8, BLINK_FRAMES=2; GLYPH_BLINK_EN selects blink expectations.
module tb_glyph_overlay_ctrl;

  localparam int CW = 10;
  localparam int X0 = 304;
  localparam int Y0 = 232;
  localparam int DF = 8;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          pix_valid;
  logic [CW-1:0] pix_x, pix_y;
  logic          req_valid;
  logic [2:0]    req_code;
  logic          req_ready, req_err, busy, rom_en;
  logic [6:0]    rom_addr;
  logic [7:0]    rom_data;
  logic          overlay_px, overlay_valid;

  int n_chk  = 0;
  int n_pass = 0;

  glyph_overlay_ctrl #(
    .CW(CW), .X0(X0), .Y0(Y0),
    .DISP_FRAMES(DF), .BLINK_FRAMES(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_start(frame_start),
    .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y),
    .req_valid(req_valid), .req_code(req_code),
    .req_ready(req_ready), .req_err(req_err),
    .busy(busy), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .overlay_px(overlay_px),
    .overlay_valid(overlay_valid)
  );

  always #5 clk = ~clk;

  // Glyph ROM: H is 8'h81 with a full bar on rows 7/8.
  function automatic logic [7:0] rom(input logic [6:0] a);
    if (a[6:4] == 3'd2)
      return (a[3:0] == 4'd7 || a[3:0] == 4'd8) ? 8'hFF : 8'h81;
    return {a[3:0], 1'b1, a[6:4]};
  endfunction

  assign rom_data = rom(rom_addr);

  function automatic bit in_box(input int x, input int y);
    return x >= X0 && x < X0 + 8 && y >= Y0 && y < Y0 + 16;
  endfunction

  function automatic bit blink_vis(input int f);
`ifdef GLYPH_BLINK_EN
    return ((f - 1) / BL) % 2 == 0;
`else
    return f > 0;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic request(input logic [2:0] c);
    req_valid = 1'b1;
    req_code  = c;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic probe(input int x, input int y,
                       input logic [2:0] c, input bit vis,
                       input string tag);
    bit         h;
    logic [6:0] a;
    logic [7:0] d;
    logic       p;
    h = vis && in_box(x, y);
    a = h ? {c, 4'(y - Y0)} : 7'd0;
    d = rom(a);
    p = h ? d[7 - (x - X0)] : 1'b0;
    pix_valid = 1'b1;
    pix_x = CW'(x);
    pix_y = CW'(y);
    tick();
    chk({tag, ".en"}, rom_en, h);
    chk({tag, ".addr"}, rom_addr, a);
    pix_valid = 1'b0;
    tick();
    chk({tag, ".ov"}, overlay_valid, h);
    chk({tag, ".px"}, overlay_px, p);
  endtask

  // Streams X0-2..X0+7 on row y, checking the 2-cycle pipeline.
  task automatic scan_row(input int y, input logic [2:0] c,
                          input bit vis, input string tag);
    bit         hv[12];
    logic       pv[12];
    logic [7:0] d;
    int         x;
    for (int i = 0; i < 12; i++) begin
      x = X0 - 2 + i;
      hv[i] = 1'b0;
      pv[i] = 1'b0;
      if (i < 10) begin
        pix_valid = 1'b1;
        pix_x = CW'(x);
        pix_y = CW'(y);
        hv[i] = vis && in_box(x, y);
        if (hv[i]) begin
          d = rom({c, 4'(y - Y0)});
          pv[i] = d[7 - (x - X0)];
        end
      end else begin
        pix_valid = 1'b0;
      end
      tick();
      chk($sformatf("%s.en%0d", tag, i), rom_en, hv[i]);
      if (hv[i])
        chk($sformatf("%s.addr%0d", tag, i), rom_addr,
            {25'd0, c, 4'(y - Y0)});
      if (i > 0) begin
        chk($sformatf("%s.ov%0d", tag, i - 1), overlay_valid, hv[i-1]);
        chk($sformatf("%s.px%0d", tag, i - 1), overlay_px, pv[i-1]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    req_valid   = 1'b0;
    req_code    = '0;
    #2;
    chk("rst.ready", req_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.en", rom_en, 0);
    chk("rst.addr", rom_addr, 0);
    chk("rst.ov", overlay_valid, 0);
    chk("rst.px", overlay_px, 0);
    chk("rst.err", req_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // H request, armed until the first frame_start
    request(3'd2);
    chk("t2.armed_busy", busy, 1);
    chk("t2.armed_rdy", req_ready, 0);
    scan_row(Y0, 3'd2, 0, "t2.pre");
    pulse_fs();
    chk("t2.show_rdy", req_ready, 1);
    scan_row(Y0, 3'd2, 1, "t2.r0");
    scan_row(Y0 + 7, 3'd2, 1, "t2.r7");
    scan_row(Y0 + 15, 3'd2, 1, "t2.r15");
    scan_row(Y0 + 16, 3'd2, 1, "t2.r16");
    scan_row(Y0 - 1, 3'd2, 1, "t2.rm1");

    // Display lifetime and blink pattern
    for (int f = 1; f <= DF; f++) begin
      if (f > 1) pulse_fs();
      chk($sformatf("t3.busy%0d", f), busy, 1);
      probe(X0 + 3, Y0 + 5, 3'd2, blink_vis(f),
            $sformatf("t6.f%0d", f));
    end
    pulse_fs();
    chk("t3.idle_busy", busy, 0);
    chk("t3.idle_rdy", req_ready, 1);
    probe(X0 + 3, Y0 + 5, 3'd2, 0, "t3.idle");

    // Illegal code
    request(3'd7);
    chk("t4.err", req_err, 1);
    chk("t4.err_busy", busy, 0);
    chk("t4.err_en", rom_en, 0);
    tick();
    chk("t4.err_end", req_err, 0);

    // Request held while armed
    request(3'd1);
    req_valid = 1'b1;
    req_code  = 3'd3;
    tick();
    chk("t4.hold0", req_ready, 0);
    tick();
    chk("t4.hold1", req_ready, 0);
    chk("t4.hold_busy", busy, 1);
    pulse_fs();
    chk("t4.show", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("t4.rearm", req_ready, 0);
    pulse_fs();
    probe(X0 + 2, Y0 + 4, 3'd3, 1, "t4.code3");

    // Replace in SHOW, then accept coincident with frame_start
    request(3'd4);
    chk("t5.armed", req_ready, 0);
    pulse_fs();
    probe(X0 + 5, Y0 + 9, 3'd4, 1, "t5.code4");
    req_valid   = 1'b1;
    req_code    = 3'd6;
    frame_start = 1'b1;
    tick();
    req_valid   = 1'b0;
    frame_start = 1'b0;
    chk("t5.co_rdy", req_ready, 0);
    chk("t5.co_busy", busy, 1);
    probe(X0 + 5, Y0 + 9, 3'd6, 0, "t5.blank");
    pulse_fs();
    probe(X0 + 7, Y0 + 15, 3'd6, 1, "t5.code6");

    // Accept on the final frame_start wins over IDLE
    for (int f = 2; f <= DF; f++) pulse_fs();
    chk("fin.busy", busy, 1);
    req_valid   = 1'b1;
    req_code    = 3'd5;
    frame_start = 1'b1;
    tick();
    req_valid   = 1'b0;
    frame_start = 1'b0;
    chk("fin.armed_busy", busy, 1);
    chk("fin.armed_rdy", req_ready, 0);
    pulse_fs();
    probe(X0, Y0, 3'd5, 1, "fin.code5");

    // Async reset mid-glyph
    pix_valid = 1'b1;
    pix_x = CW'(X0 + 1);
    pix_y = CW'(Y0 + 2);
    tick();
    tick();
    chk("t1.pre_ov", overlay_valid, 1);
    chk("t1.pre_en", rom_en, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1.en", rom_en, 0);
    chk("t1.ov", overlay_valid, 0);
    chk("t1.px", overlay_px, 0);
    chk("t1.rdy", req_ready, 1);
    chk("t1.busy", busy, 0);
    pix_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Pending armed request lost on reset
    request(3'd1);
    chk("t1.arm_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1.lost_busy", busy, 0);
    chk("t1.lost_rdy", req_ready, 1);
    rst_n = 1'b1;
    tick();
    pulse_fs();
    chk("t1.after_fs", busy, 0);
    probe(X0 + 1, Y0 + 1, 3'd1, 0, "t1.nodisp");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
